// File: rtl/ifmp1_slave_rx.sv
// Slave endpoint for the ifmp1 toggle handshake: accepts request words into a
// small FIFO and presents them on a first-word-fall-through read port.
//
// state   | meaning
// IDLE    | req == ack, nothing outstanding
// PENDING | req != ack, FIFO has room: push and toggle ack at the next edge
// STALL   | req != ack, FIFO full: hold ack until an entry frees up
module ifmp1_slave_rx #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BUS_WIDTH-1:0]         sig1,
    output logic                         sig2,
    output logic [BUS_WIDTH-2:0]         rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         proto_err
);

    localparam int PW = BUS_WIDTH - 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          chk_q, chk_d;
    logic [PW-1:0] prev_q, prev_d;

    logic          req;
    logic [PW-1:0] payload;
    logic          pending;
    logic          full;
    logic          push;
    logic          pop;

    assign req     = sig1[BUS_WIDTH-1];
    assign payload = sig1[BUS_WIDTH-2:0];
    assign pending = (req != ack_q);
    // Full is judged on start-of-cycle occupancy, so a same-cycle pop never admits a push.
    assign full    = (level_q == LW'(DEPTH));
    assign push    = pending && !full;
    assign pop     = (level_q != '0) && rd_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = payload;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Only a request that stays outstanding across an edge is compared against
    // its previous payload; a fresh request right after an ack starts clean.
    always_comb begin
        ack_d  = ack_q ^ push;
        chk_d  = pending && !push;
        prev_d = payload;
        err_d  = err_q;
        if (pending && chk_q && (payload != prev_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            chk_q    <= 1'b0;
            prev_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            chk_q    <= chk_d;
            prev_q   <= prev_d;
        end
    end

    assign sig2      = ack_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign rd_valid  = (level_q != '0);
    assign level     = level_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_ifmp1_slave_rx.sv
// Directed bench for ifmp1_slave_rx: expected words go into a scoreboard queue,
// and a negedge monitor checks every popped word against it.
module tb_ifmp1_slave_rx;

    localparam int BW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] sig1;
    logic          sig2;
    logic [BW-2:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [2:0]    level;
    logic          proto_err;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [BW-2:0] sb [$];
    logic          req_r;

    ifmp1_slave_rx #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig1      (sig1),
        .sig2      (sig2),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [BW-2:0] d, input bit expect_push);
        req_r = ~req_r;
        sig1  = {req_r, d};
        if (expect_push) sb.push_back(d);
    endtask

    task automatic wait_ack(input string name, input int budget);
        int k;
        k = 0;
        while (sig2 !== req_r && k < budget) begin
            step();
            k++;
        end
        check(name, {31'd0, sig2}, {31'd0, req_r});
    endtask

    task automatic send(input logic [BW-2:0] d);
        issue(d, 1'b1);
        wait_ack("ack", 8);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step();
        rd_ready = 1'b0;
    endtask

    // Monitor: every pop observed on the port must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
            end else begin
                if (rd_data !== sb[0]) begin
                    n_bad++;
                    $display("FAIL pop_data: got %0h expected %0h", rd_data, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n    = 1'b0;
        sig1     = '0;
        rd_ready = 1'b0;
        req_r    = 1'b0;

        // reset and single word
        repeat (2) step();
        check("rst_sig2",  {31'd0, sig2},      0);
        check("rst_valid", {31'd0, rd_valid},  0);
        check("rst_level", {29'd0, level},     0);
        check("rst_err",   {31'd0, proto_err}, 0);
        check("rst_data",  {1'b0, rd_data},    0);
        rst_n = 1'b1;
        step();
        issue(31'h1234, 1'b1);
        step();
        check("w1_sig2",  {31'd0, sig2},     1);
        check("w1_valid", {31'd0, rd_valid}, 1);
        check("w1_data",  {1'b0, rd_data},   32'h1234);
        check("w1_level", {29'd0, level},    1);
        drain(1);
        check("w1_drained", {29'd0, level}, 0);

        // fill and stall
        for (int i = 0; i < 4; i++) send(31'h11 + 31'(i));
        check("fill_level", {29'd0, level}, 4);
        issue(31'h15, 1'b1);
        repeat (3) step();
        check("stall_sig2",  {31'd0, sig2},  {31'd0, ~req_r});
        check("stall_level", {29'd0, level}, 4);
        drain(1);
        check("rel_m_level", {29'd0, level}, 3);
        check("rel_m_sig2",  {31'd0, sig2},  {31'd0, ~req_r});
        step();
        check("rel_m1_level", {29'd0, level}, 4);
        check("rel_m1_sig2",  {31'd0, sig2},  {31'd0, req_r});
        drain(4);
        check("fill_empty", {29'd0, level}, 0);

        // wrap-around streaming
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(31'hA0 + 31'(i));
            check("wrap_level_le1", {31'd0, (level <= 3'd1)}, 1);
        end
        repeat (2) step();
        rd_ready = 1'b0;
        check("wrap_empty", {29'd0, level},     0);
        check("wrap_noerr", {31'd0, proto_err}, 0);
        check("wrap_sb",    sb.size(),          0);

        // simultaneous push and pop at level 2
        send(31'hB0);
        send(31'hB1);
        check("sim_pre_level", {29'd0, level}, 2);
        issue(31'hB2, 1'b1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("sim_level", {29'd0, level}, 2);
        check("sim_sig2",  {31'd0, sig2},  {31'd0, req_r});
        drain(2);
        check("sim_empty", {29'd0, level}, 0);

        // protocol violation while stalled
        for (int i = 0; i < 4; i++) send(31'hC0 + 31'(i));
        check("pv_full",  {29'd0, level},     4);
        check("pv_noerr", {31'd0, proto_err}, 0);
        issue(31'h55, 1'b0);
        step();
        sig1 = {req_r, 31'h66};
        sb.push_back(31'h66);
        step();
        check("pv_err", {31'd0, proto_err}, 1);
        repeat (2) step();
        check("pv_sticky", {31'd0, proto_err}, 1);
        check("pv_hold",   {31'd0, sig2},      {31'd0, ~req_r});
        drain(1);
        wait_ack("pv_ack", 4);
        drain(4);
        check("pv_empty",   {29'd0, level},     0);
        check("pv_sticky2", {31'd0, proto_err}, 1);
        check("pv_sb",      sb.size(),          0);

        // reset mid-operation with a request pending and req = 1
        if (req_r == 1'b0) begin
            send(31'hE0);
            drain(1);
        end
        for (int i = 0; i < 3; i++) send(31'hD0 + 31'(i));
        check("mr_level", {29'd0, level}, 3);
        issue(31'hD3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_level0", {29'd0, level},     0);
        check("mr_valid0", {31'd0, rd_valid},  0);
        check("mr_sig20",  {31'd0, sig2},      0);
        check("mr_err0",   {31'd0, proto_err}, 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        sb.push_back(31'hD3);
        wait_ack("mr_ack", 4);
        check("mr_one", {29'd0, level},   1);
        check("mr_data", {1'b0, rd_data}, 32'hD3);
        drain(1);
        repeat (3) step();
        check("mr_final_level", {29'd0, level}, 0);
        check("mr_final_sb",    sb.size(),      0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
